// File: rtl/microarch_defs.sv
// Shared control-word layout, opcode map and T-state constants for the
// microcoded control sequencer.
package microarch_defs;

    typedef struct packed {
        logic pc_enable;
        logic load_pc;
        logic oe_pc;
        logic load_mar;
        logic oe_ram;
        logic we_ram;
        logic load_ir;
        logic oe_ir;
        logic load_a;
        logic oe_a;
        logic load_b;
        logic alu_sub;
        logic oe_alu;
        logic load_flags;
        logic load_out;
        logic halt;
    } control_word_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;

    localparam control_word_t CW_NONE = control_word_t'(16'h0000);

endpackage

// File: rtl/microcode_decoder.sv
// Pure combinational microcode ROM: (step, opcode, flags) -> control word
// plus a flag marking the final T-state of the instruction.
module microcode_decoder
    import microarch_defs::*;
#(
    parameter int STEP_WIDTH = 3
) (
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [3:0]            opcode,
    input  logic                  flag_zero,
    input  logic                  flag_carry,
    output control_word_t         control_word,
    output logic                  last
);

    opcode_e op;
    assign op = opcode_e'(opcode);

    always_comb begin
        control_word = CW_NONE;
        last         = 1'b0;
        case (step)
            STEP_WIDTH'(T0): begin
                control_word.oe_pc    = 1'b1;
                control_word.load_mar = 1'b1;
            end
            STEP_WIDTH'(T1): begin
                control_word.oe_ram    = 1'b1;
                control_word.load_ir   = 1'b1;
                control_word.pc_enable = 1'b1;
            end
            STEP_WIDTH'(T2): begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        control_word.oe_ir    = 1'b1;
                        control_word.load_mar = 1'b1;
                    end
                    OP_LDI: begin
                        control_word.oe_ir  = 1'b1;
                        control_word.load_a = 1'b1;
                        last                = 1'b1;
                    end
                    OP_JMP: begin
                        control_word.oe_ir   = 1'b1;
                        control_word.load_pc = 1'b1;
                        last                 = 1'b1;
                    end
                    OP_JC: begin
                        control_word.oe_ir   = flag_carry;
                        control_word.load_pc = flag_carry;
                        last                 = 1'b1;
                    end
                    OP_JZ: begin
                        control_word.oe_ir   = flag_zero;
                        control_word.load_pc = flag_zero;
                        last                 = 1'b1;
                    end
                    OP_OUT: begin
                        control_word.oe_a     = 1'b1;
                        control_word.load_out = 1'b1;
                        last                  = 1'b1;
                    end
                    // HLT is not "last": the step counter freezes on it instead.
                    OP_HLT: control_word.halt = 1'b1;
                    default: last = 1'b1;
                endcase
            end
            STEP_WIDTH'(T3): begin
                case (op)
                    OP_LDA: begin
                        control_word.oe_ram = 1'b1;
                        control_word.load_a = 1'b1;
                        last                = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        control_word.oe_ram = 1'b1;
                        control_word.load_b = 1'b1;
                    end
                    OP_STA: begin
                        control_word.oe_a   = 1'b1;
                        control_word.we_ram = 1'b1;
                        last                = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            STEP_WIDTH'(T4): begin
                if (op == OP_ADD || op == OP_SUB) begin
                    control_word.oe_alu     = 1'b1;
                    control_word.load_a     = 1'b1;
                    control_word.load_flags = 1'b1;
                    control_word.alu_sub    = (op == OP_SUB);
                end
                last = 1'b1;
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer top: T-state counter, sticky halt latch and reset/halt
// gating around the combinational microcode decoder.
module control_sequencer
    import microarch_defs::*;
#(
    parameter int NUM_STEPS  = 5,
    parameter int STEP_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            opcode,
    input  logic                  flag_zero,
    input  logic                  flag_carry,
    output logic [15:0]           control_word,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  halted
);

    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  halted_q, halted_d;
    control_word_t         dec_cw;
    logic                  dec_last;

    microcode_decoder #(
        .STEP_WIDTH (STEP_WIDTH)
    ) u_decoder (
        .step         (step_q),
        .opcode       (opcode),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .control_word (dec_cw),
        .last         (dec_last)
    );

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q | dec_cw.halt;
        // The step holds on HLT's T2 as well, so a halted machine reports T2.
        if (!halted_q && !dec_cw.halt) begin
            if (dec_last || step_q == STEP_WIDTH'(NUM_STEPS - 1))
                step_d = '0;
            else
                step_d = step_q + STEP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign control_word = (reset || halted_q) ? 16'(CW_NONE) : 16'(dec_cw);
    assign step         = step_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute words per opcode,
// conditional jumps, halt latching, reset abort and bus-contention invariants.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        flag_zero;
    logic        flag_carry;
    logic [15:0] control_word;
    logic [2:0]  step;
    logic        halted;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] W_T0     = 16'h3000;
    localparam logic [15:0] W_T1     = 16'h8A00;
    localparam logic [15:0] W_MAR_IR = 16'h1100;
    localparam logic [15:0] W_LDA_T3 = 16'h0880;
    localparam logic [15:0] W_ADD_T3 = 16'h0820;
    localparam logic [15:0] W_ADD_T4 = 16'h008C;
    localparam logic [15:0] W_SUB_T4 = 16'h009C;
    localparam logic [15:0] W_STA_T3 = 16'h0440;
    localparam logic [15:0] W_LDI_T2 = 16'h0180;
    localparam logic [15:0] W_JMP_T2 = 16'h4100;
    localparam logic [15:0] W_OUT_T2 = 16'h0042;
    localparam logic [15:0] W_HLT_T2 = 16'h0001;

    control_sequencer #(
        .NUM_STEPS  (5),
        .STEP_WIDTH (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .control_word (control_word),
        .step         (step),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check step and word at the current point, then advance to the next negedge.
    task automatic expect_step(input string tag, input logic [2:0] s, input logic [15:0] w);
        #1;
        chk({tag, "_step"}, {13'd0, step}, {13'd0, s});
        chk({tag, "_cw"}, control_word, w);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        opcode     = 4'h0;
        flag_zero  = 1'b0;
        flag_carry = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cw", control_word, 16'h0000);
        chk("rst_step", {13'd0, step}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset aborting ADD in T3
        opcode = 4'h2;
        expect_step("add_t0", 3'd0, W_T0);
        expect_step("add_t1", 3'd1, W_T1);
        expect_step("add_t2", 3'd2, W_MAR_IR);
        #1;
        chk("add_t3_cw", control_word, W_ADD_T3);
        reset = 1'b1;
        #1;
        chk("rst_mid_cw", control_word, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_hold_cw", control_word, 16'h0000);
            chk("rst_hold_step", {13'd0, step}, 16'd0);
        end
        reset = 1'b0;

        // LDA: 4-cycle instruction
        opcode = 4'h1;
        expect_step("lda_t0", 3'd0, W_T0);
        expect_step("lda_t1", 3'd1, W_T1);
        expect_step("lda_t2", 3'd2, W_MAR_IR);
        expect_step("lda_t3", 3'd3, W_LDA_T3);

        // ADD then SUB: 5-cycle, wrap 4->0
        opcode = 4'h2;
        expect_step("add2_t0", 3'd0, W_T0);
        expect_step("add2_t1", 3'd1, W_T1);
        expect_step("add2_t2", 3'd2, W_MAR_IR);
        expect_step("add2_t3", 3'd3, W_ADD_T3);
        expect_step("add2_t4", 3'd4, W_ADD_T4);
        opcode = 4'h3;
        expect_step("sub_t0", 3'd0, W_T0);
        expect_step("sub_t1", 3'd1, W_T1);
        expect_step("sub_t2", 3'd2, W_MAR_IR);
        expect_step("sub_t3", 3'd3, W_ADD_T3);
        expect_step("sub_t4", 3'd4, W_SUB_T4);

        // STA, LDI, JMP, OUT
        opcode = 4'h4;
        expect_step("sta_t0", 3'd0, W_T0);
        expect_step("sta_t1", 3'd1, W_T1);
        expect_step("sta_t2", 3'd2, W_MAR_IR);
        expect_step("sta_t3", 3'd3, W_STA_T3);
        opcode = 4'h5;
        expect_step("ldi_t0", 3'd0, W_T0);
        expect_step("ldi_t1", 3'd1, W_T1);
        expect_step("ldi_t2", 3'd2, W_LDI_T2);
        opcode = 4'h6;
        expect_step("jmp_t0", 3'd0, W_T0);
        expect_step("jmp_t1", 3'd1, W_T1);
        expect_step("jmp_t2", 3'd2, W_JMP_T2);
        opcode = 4'hE;
        expect_step("out_t0", 3'd0, W_T0);
        expect_step("out_t1", 3'd1, W_T1);
        expect_step("out_t2", 3'd2, W_OUT_T2);

        // JZ not taken / taken; carry set must not matter for JZ
        opcode = 4'h8; flag_zero = 1'b0; flag_carry = 1'b1;
        expect_step("jz0_t0", 3'd0, W_T0);
        expect_step("jz0_t1", 3'd1, W_T1);
        expect_step("jz0_t2", 3'd2, 16'h0000);
        flag_zero = 1'b1; flag_carry = 1'b0;
        expect_step("jz1_t0", 3'd0, W_T0);
        expect_step("jz1_t1", 3'd1, W_T1);
        expect_step("jz1_t2", 3'd2, W_JMP_T2);

        // JC not taken / taken
        opcode = 4'h7; flag_zero = 1'b1; flag_carry = 1'b0;
        expect_step("jc0_t0", 3'd0, W_T0);
        expect_step("jc0_t1", 3'd1, W_T1);
        expect_step("jc0_t2", 3'd2, 16'h0000);
        flag_zero = 1'b0; flag_carry = 1'b1;
        expect_step("jc1_t0", 3'd0, W_T0);
        expect_step("jc1_t1", 3'd1, W_T1);
        expect_step("jc1_t2", 3'd2, W_JMP_T2);
        flag_carry = 1'b0;

        // Undefined opcode 0xB
        opcode = 4'hB;
        expect_step("undef_t0", 3'd0, W_T0);
        expect_step("undef_t1", 3'd1, W_T1);
        expect_step("undef_t2", 3'd2, 16'h0000);
        expect_step("undef_next", 3'd0, W_T0);

        // HLT: halt bit for one cycle, then frozen
        expect_step("hlt_pre_t1", 3'd1, W_T1);
        opcode = 4'hF;
        expect_step("hlt_t2", 3'd2, W_HLT_T2);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'(i);
            flag_zero = i[0];
            #1;
            chk("halt_flag", {15'd0, halted}, 16'd1);
            chk("halt_step", {13'd0, step}, 16'd2);
            chk("halt_cw", control_word, 16'h0000);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("unhalt_flag", {15'd0, halted}, 16'd0);
        chk("unhalt_step", {13'd0, step}, 16'd0);
        chk("unhalt_cw", control_word, W_T0);
        @(negedge clk);

        // Random opcode stream (HLT excluded) against the bus invariants
        for (int i = 0; i < 1000; i++) begin
            opcode     = 4'($urandom_range(14, 0));
            flag_zero  = 1'($urandom_range(1, 0));
            flag_carry = 1'($urandom_range(1, 0));
            #1;
            chk("oe_onehot",
                16'($countones({control_word[13], control_word[11], control_word[8],
                                control_word[6], control_word[3]}) <= 1), 16'd1);
            chk("we_vs_oe_ram", {15'd0, control_word[10] & control_word[11]}, 16'd0);
            chk("ldpc_vs_pcen", {15'd0, control_word[14] & control_word[15]}, 16'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
